// File: rtl/sdp_mrd.sv
// sdp_mrd: RAM with one write port and NRD independent read ports.
// The write port is always ready. Each read port has a credit counter and a
// fall-through output FIFO of depth RD_LATENCY+1, so rd_addr_ready comes from
// registers only and never from rd_data_ready.
// Optional macro SDP_MRD_WR_FIRST_EN: when a read collides with a same-edge
// write to the same address, the read returns the write data (write-first).
// Default build (macro undefined): the read returns the old contents
// (read-first), and the RAM has no bypass logic.
module sdp_mrd #(
   parameter int W_DATA     = 16,
   parameter int W_ADDR     = 10,
   parameter int DEPTH      = 1024,
   parameter int NRD        = 2,
   parameter int RD_LATENCY = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_addr_data_valid,
   output logic                     wr_addr_data_ready,
   input  logic [W_DATA+W_ADDR-1:0] wr_addr_data,
   input  logic [NRD-1:0]           rd_addr_valid,
   output logic [NRD-1:0]           rd_addr_ready,
   input  logic [NRD*W_ADDR-1:0]    rd_addr,
   output logic [NRD-1:0]           rd_data_valid,
   input  logic [NRD-1:0]           rd_data_ready,
   output logic [NRD*W_DATA-1:0]    rd_data
);
   localparam int B  = RD_LATENCY + 1;   // per-port credits and FIFO depth
   localparam int PW = $clog2(B);        // FIFO pointer width
   localparam int CW = $clog2(B + 1);    // width of the 0..B counters

   logic [W_DATA-1:0] mem [DEPTH];
   logic [W_ADDR-1:0] wr_addr;
   logic [W_DATA-1:0] wr_data;
   logic              wr_en;

   function automatic logic in_range(input logic [W_ADDR-1:0] a);
      return 32'(a) < 32'(DEPTH);
   endfunction

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(B - 1)) ? '0 : p + 1'b1;
   endfunction

   assign wr_addr            = wr_addr_data[W_ADDR-1:0];
   assign wr_data            = wr_addr_data[W_ADDR +: W_DATA];
   assign wr_en              = wr_addr_data_valid & in_range(wr_addr);
   assign wr_addr_data_ready = 1'b1;

   // Write port: an out-of-range write is dropped.
   // NOTE: the RAM array has no reset. This lets it map onto block RAM, and its contents survive rst.
   always_ff @(posedge clk)
      if (wr_en) mem[wr_addr] <= wr_data;

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [W_ADDR-1:0] addr;
      logic              accept, hs, push, pop;
      logic [W_DATA-1:0] mem_q, stage1, pipe_data;
      logic              rng_q, v1, pipe_valid;
      logic [W_DATA-1:0] fifo [B];
      logic [PW-1:0]     wp, rp;
      logic [CW-1:0]     fcnt, cnt;

      assign addr   = rd_addr[i*W_ADDR +: W_ADDR];
      assign accept = rd_addr_valid[i] & rd_addr_ready[i];

      // RAM output register and range flag, loaded when a read is accepted.
      // NOTE: the write above is non-blocking, so a read on the same edge still samples the old word.
      always_ff @(posedge clk)
         if (accept) begin
            mem_q <= mem[addr];
            rng_q <= in_range(addr);
         end

`ifdef SDP_MRD_WR_FIRST_EN
      logic              hit_q;
      logic [W_DATA-1:0] byp_q;

      // Capture a same-edge write to the address being read, for the bypass mux.
      always_ff @(posedge clk)
         if (accept) begin
            hit_q <= wr_addr_data_valid && (wr_addr == addr);
            byp_q <= wr_data;
         end

      assign stage1 = !rng_q ? '0 : (hit_q ? byp_q : mem_q);
`else
      assign stage1 = rng_q ? mem_q : '0;
`endif

      // Read-issue flag. Clearing it on reset discards reads in flight.
      always_ff @(posedge clk or negedge rst)
         if (!rst) v1 <= 1'b0;
         else      v1 <= accept;

      if (RD_LATENCY == 2) begin : g_lat2
         logic [W_DATA-1:0] d2;
         logic              v2;

         // Extra output register stage, for timing.
         always_ff @(posedge clk)
            if (v1) d2 <= stage1;

         // Valid flag of the extra stage.
         always_ff @(posedge clk or negedge rst)
            if (!rst) v2 <= 1'b0;
            else      v2 <= v1;

         assign pipe_valid = v2;
         assign pipe_data  = d2;
      end else begin : g_lat1
         assign pipe_valid = v1;
         assign pipe_data  = stage1;
      end

      // Fall-through FIFO. When it is empty, pipeline data passes straight to the output.
      assign rd_data_valid[i]             = (fcnt != '0) | pipe_valid;
      assign rd_data[i*W_DATA +: W_DATA]  = (fcnt != '0) ? fifo[rp] : pipe_data;
      assign hs                           = rd_data_valid[i] & rd_data_ready[i];
      assign pop                          = (fcnt != '0) & rd_data_ready[i];
      assign push                         = pipe_valid & ~((fcnt == '0) & rd_data_ready[i]);
      assign rd_addr_ready[i]             = (cnt < CW'(B));

      // FIFO storage. It is written at the tail and needs no reset.
      always_ff @(posedge clk)
         if (push) fifo[wp] <= pipe_data;

      // FIFO pointers, FIFO occupancy, and the credit count (in flight + buffered).
      always_ff @(posedge clk or negedge rst)
         if (!rst) begin
            wp   <= '0;
            rp   <= '0;
            fcnt <= '0;
            cnt  <= '0;
         end else begin
            if (push) wp <= ptr_inc(wp);
            if (pop)  rp <= ptr_inc(rp);
            case ({push, pop})
               2'b10:   fcnt <= fcnt + 1'b1;
               2'b01:   fcnt <= fcnt - 1'b1;
               default: ;
            endcase
            case ({accept, hs})
               2'b10:   cnt <= cnt + 1'b1;
               2'b01:   cnt <= cnt - 1'b1;
               default: ;
            endcase
         end
   end

endmodule

// File: tb/tb_sdp_mrd.sv
// tb_sdp_mrd: directed bench for sdp_mrd. It uses two instances:
//   u=0: RD_LATENCY=1, DEPTH=1024
//   u=1: RD_LATENCY=2, DEPTH=1000
// Each instance gets fill/stream, backpressure, collision, multi-port,
// out-of-range, and mid-operation reset sequences.
module tb_sdp_mrd;
   localparam int WD  = 16;
   localparam int WA  = 10;
   localparam int NRD = 2;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic                 wv   [2];
   logic                 wrdy [2];
   logic [WD+WA-1:0]     wad  [2];
   logic [NRD-1:0]       av   [2];
   logic [NRD-1:0]       ardy [2];
   logic [NRD-1:0]       dv   [2];
   logic [NRD-1:0]       dr   [2];
   logic [NRD*WA-1:0]    a    [2];
   logic [NRD*WD-1:0]    d    [2];
   int                   cyc   = 0;
   int                   n_cmp = 0;
   int                   n_bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      sdp_mrd #(
         .W_DATA(WD), .W_ADDR(WA), .DEPTH(g == 0 ? 1024 : 1000),
         .NRD(NRD), .RD_LATENCY(g + 1)
      ) u_dut (
         .clk                (clk),
         .rst                (rst),
         .wr_addr_data_valid (wv[g]),
         .wr_addr_data_ready (wrdy[g]),
         .wr_addr_data       (wad[g]),
         .rd_addr_valid      (av[g]),
         .rd_addr_ready      (ardy[g]),
         .rd_addr            (a[g]),
         .rd_data_valid      (dv[g]),
         .rd_data_ready      (dr[g]),
         .rd_data            (d[g])
      );
   end

   function automatic int lat(input int u);
      return u + 1;
   endfunction

   function automatic int dep(input int u);
      return (u == 0) ? 1024 : 1000;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wr(input int u, input int addr, input int data);
      @(negedge clk);
      wv[u]  = 1'b1;
      wad[u] = {16'(data), 10'(addr)};
      @(negedge clk);
      wv[u]  = 1'b0;
   endtask

   // Present the addresses in order. first_cyc is the cycle of the first accept.
   task automatic issue(input int u, input int p, input int q[$], output int first_cyc);
      int idx   = 0;
      int guard = 0;
      first_cyc = -1;
      while (idx < q.size() && guard < 200) begin
         @(negedge clk);
         guard++;
         av[u][p]          = 1'b1;
         a[u][p*WA +: WA]  = 10'(q[idx]);
         if (ardy[u][p]) begin
            if (idx == 0) first_cyc = cyc;
            idx++;
         end
      end
      check($sformatf("u%0d p%0d issued", u, p), 32'(idx), 32'(q.size()));
      @(negedge clk);
      av[u][p] = 1'b0;
   endtask

   // Drive rd_data_ready and compare each beat with the expected list.
   // mode 0: ready always high; mode 1: ready toggles 1010...; mode 2: ready low for 5 cycles, then high.
   task automatic collect(input int u, input int p, input int q[$], input int mode,
                          input int budget, output int first_cyc, output int gaps);
      int   idx  = 0;
      int   last = -1;
      logic r;
      first_cyc = -1;
      gaps      = 0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         case (mode)
            1:       r = (k % 2 == 0);
            2:       r = (k >= 5);
            default: r = 1'b1;
         endcase
         dr[u][p] = r;
         if (dv[u][p] && r) begin
            if (idx < q.size())
               check($sformatf("u%0d p%0d beat %0d", u, p, idx), 32'(d[u][p*WD +: WD]), 32'(q[idx]));
            else
               check($sformatf("u%0d p%0d extra beat", u, p), 32'(idx + 1), 32'(q.size()));
            if (idx == 0) first_cyc = cyc;
            else if (cyc != last + 1) gaps++;
            last = cyc;
            idx++;
         end
      end
      dr[u][p] = 1'b0;
      check($sformatf("u%0d p%0d beat count", u, p), 32'(idx), 32'(q.size()));
   endtask

   // During the 5-cycle stall: ready drops after B accepts and the head word is held.
   task automatic watch_stall(input int u);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("u%0d stall ready k%0d", u, k), 32'(ardy[u][1]), 32'(k < lat(u) + 1));
         check($sformatf("u%0d stall valid k%0d", u, k), 32'(dv[u][1]), 32'(k >= lat(u)));
         if (k >= lat(u))
            check($sformatf("u%0d stall head k%0d", u, k), 32'(d[u][WD +: WD]), 32'hA000);
      end
   endtask

   task automatic run_tests(input int u);
      int q[$];
      int e[$];
      int fa, fb, f1, c0, c1, g0, g1;
      int coll;

      // Fill, then stream on port 0 with ready high.
      for (int i = 0; i < 16; i++) wr(u, i, 32'hA000 + i);
      q = {}; e = {};
      for (int i = 0; i < 16; i++) begin q.push_back(i); e.push_back(32'hA000 + i); end
      fork
         issue(u, 0, q, fa);
         collect(u, 0, e, 0, 40, fb, g0);
      join
      check($sformatf("u%0d stream latency", u), 32'(fb - fa), 32'(lat(u)));
      check($sformatf("u%0d stream gaps", u), 32'(g0), 32'd0);

      // Backpressure on port 1.
      q = {}; e = {};
      for (int i = 0; i < 11; i++) begin q.push_back(i); e.push_back(32'hA000 + i); end
      fork
         issue(u, 1, q, fa);
         collect(u, 1, e, 2, 40, fb, g1);
         watch_stall(u);
      join

      // Same-edge write and read of addr 5, then a read on the next cycle.
      wr(u, 5, 32'h0BAD);
`ifdef SDP_MRD_WR_FIRST_EN
      coll = 32'h1234;
`else
      coll = 32'h0BAD;
`endif
      e = {};
      e.push_back(coll);
      e.push_back(32'h1234);
      fork
         begin
            @(negedge clk);
            check($sformatf("u%0d collide ready", u), 32'(ardy[u][0]), 32'd1);
            wv[u]       = 1'b1;
            wad[u]      = {16'h1234, 10'd5};
            av[u][0]    = 1'b1;
            a[u][WA-1:0] = 10'd5;
            @(negedge clk);
            wv[u]       = 1'b0;
            check($sformatf("u%0d collide ready2", u), 32'(ardy[u][0]), 32'd1);
            @(negedge clk);
            av[u][0]    = 1'b0;
         end
         collect(u, 0, e, 0, 20, fb, g0);
      join

      // Both ports read addr 7; port 1 ready toggles.
      q = {}; e = {};
      for (int i = 0; i < 6; i++) begin q.push_back(7); e.push_back(32'hA007); end
      fork
         issue(u, 0, q, fa);
         issue(u, 1, q, f1);
         collect(u, 0, e, 0, 40, c0, g0);
         collect(u, 1, e, 1, 40, c1, g1);
      join
      check($sformatf("u%0d mp port0 latency", u), 32'(c0 - fa), 32'(lat(u)));
      check($sformatf("u%0d mp port0 gaps", u), 32'(g0), 32'd0);

      // Out-of-range write and read, plus the last valid address.
      wr(u, 999, 32'h5A5A);
      wr(u, 1010, 32'hDEAD);
      q = {1010, 999};
      e = {};
      e.push_back((1010 < dep(u)) ? 32'hDEAD : 32'h0);
      e.push_back(32'h5A5A);
      fork
         issue(u, 0, q, fa);
         collect(u, 0, e, 0, 20, fb, g0);
      join

      // Reset while reads are in flight and one word is buffered (ready held low).
      q = {};
      for (int i = 0; i < lat(u) + 1; i++) q.push_back(i);
      issue(u, 0, q, fa);
      check($sformatf("u%0d pre-reset valid", u), 32'(dv[u][0]), 32'd1);
      #1 rst = 1'b0;
      #1 check($sformatf("u%0d async valid drop", u), 32'(dv[u]), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("u%0d post-reset ready k%0d", u, k), 32'(ardy[u]), 32'h3);
         check($sformatf("u%0d post-reset valid k%0d", u, k), 32'(dv[u]), 32'd0);
      end
      q = {3};
      e = {};
      e.push_back(32'hA003);
      fork
         issue(u, 0, q, fa);
         collect(u, 0, e, 0, 20, fb, g0);
      join
      check($sformatf("u%0d post-reset latency", u), 32'(fb - fa), 32'(lat(u)));
   endtask

   initial begin
      for (int u = 0; u < 2; u++) begin
         wv[u]  = 1'b0;
         wad[u] = '0;
         av[u]  = '0;
         dr[u]  = '0;
         a[u]   = '0;
      end
      #23;
      for (int u = 0; u < 2; u++) begin
         check($sformatf("u%0d reset valid", u), 32'(dv[u]), 32'd0);
         check($sformatf("u%0d reset addr ready", u), 32'(ardy[u]), 32'h3);
         check($sformatf("u%0d write ready", u), 32'(wrdy[u]), 32'd1);
      end
      @(negedge clk);
      rst = 1'b1;
      for (int u = 0; u < 2; u++) run_tests(u);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
